wb_commit_stage: RTL and testbench
==================================

# wb_commit_stage

Parametrised writeback commit stage for the pipelined MIPS core: registers the M/W boundary, selects the register-file write data from N generic sources or the link address, applies load sign/zero extension, and presents one registered write port to the GRF. It also maintains a retired-instruction counter. It sits between the memory stage and the GRF, replacing a bare W-stage data mux.

## Interface
- DATA_W, 32, datapath width
- NSRC, 3, number of generic data sources on the packed bus
- DM_SRC, 1, source index that carries DM read data (load extension applies)
- PC_OFFSET, 8, link offset added to PC when link is selected
- AW, 5, register address width
- Derived SEL_W = $clog2(NSRC+1)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- en  in  1  stage advance; 0 = stall (hold W contents)
- flush  in  1  insert bubble into W
- m_valid  in  1  M-stage instruction valid
- m_sel  in  SEL_W  source select; 0..NSRC-1 = generic source, NSRC = link
- m_src  in  NSRC*DATA_W  packed sources, source i at [i*DATA_W +: DATA_W]
- m_pc  in  DATA_W  PC of the M-stage instruction
- m_wa  in  AW  destination register
- m_we  in  1  register write requested
- m_ld_type  in  3  000 word, 001 lbu, 010 lb, 011 lhu, 100 lh
- m_addr_lo  in  2  low byte-address bits of the load
- w_valid  out  1  W holds a valid instruction
- w_we  out  1  GRF write enable
- w_wa  out  AW  GRF write address
- w_wd  out  DATA_W  GRF write data
- w_pc  out  DATA_W  PC of the W instruction
- w_retire_cnt  out  32  count of committed instructions

## Operation
- Data select (combinational, M side): m_sel < NSRC -> source m_sel; m_sel == NSRC -> m_pc + PC_OFFSET (mod 2^DATA_W); m_sel > NSRC -> data 0, write suppressed.
- Extension only when m_sel == DM_SRC. Byte = word[8*m_addr_lo +: 8]; half = word[16*m_addr_lo[1] +: 16]; lb/lh sign-extend, lbu/lhu zero-extend, word and undefined ld_type codes pass raw.
- Write qualification: w_we <= m_valid & m_we & (m_wa != 0) & (m_sel <= NSRC).
- Priority: reset > flush > en.
  - reset low: w_valid, w_we = 0; w_wa, w_wd, w_pc = 0; w_retire_cnt = 0.
  - flush: w_valid, w_we = 0; other W fields = 0, regardless of en.
  - en high: load all W fields from M.
  - en low: hold all W fields.
- Retire counter: increments by 1 on each cycle with w_valid = 1 and en = 1 (one commit per advance), wraps 0xFFFFFFFF -> 0; holds on stall; not cleared by flush.

## Timing
- Latency 1 cycle: M inputs sampled at edge t appear on w_* after t.
- All outputs registered; no combinational M->W path.
- A stalled W instruction keeps w_we asserted; the GRF write repeats the same value, which is idempotent.
- flush and en high in the same cycle: bubble wins.
- reset low mid-stream: outputs at reset values on the next edge; the first valid commit follows one cycle after reset returns high with en = 1.

## Configuration
- WB_LOAD_EXT_EN defined: byte/half extension as above.
- Not defined: m_ld_type and m_addr_lo are ignored, DM_SRC data passes raw (word loads only); port list unchanged.

## Structure
- Shared package wb_pkg: load-type encodings (LD_WORD, LD_LBU, LD_LB, LD_LHU, LD_LH) and the default PC_OFFSET constant.
- One sub-module: wb_load_ext (combinational: word, ld_type, addr_lo -> extended data), instantiated under WB_LOAD_EXT_EN.

## Test plan
- Reset: hold reset low 2 cycles with random inputs -> all outputs 0, w_retire_cnt = 0.
- Select: NSRC=3, m_src = {0x33,0x22,0x11} for i = 2,1,0, m_sel = 0,2,3, m_pc = 0x3000 -> w_wd = 0x11, 0x33, 0x3008 on consecutive cycles.
- Load extension: DM word 0x80FF7F01, lb addr_lo=3 -> 0xFFFFFF80; lbu addr_lo=3 -> 0x00000080; lh addr_lo=2 -> 0xFFFF80FF; lhu addr_lo=0 -> 0x00007F01. With macro off, all -> 0x80FF7F01.
- $zero and bad select: m_wa = 0, m_we = 1 -> w_we = 0; m_sel = 3 (NSRC=2) -> w_we = 0, w_wd = 0.
- Stall/flush: en = 0 for 3 cycles -> w_* held, count unchanged; flush = 1 with en = 1 -> w_valid = 0, w_we = 0, count unchanged.
- Counter wrap: preset count to 0xFFFFFFFF via 2^32-1 commits (or force) plus one commit -> w_retire_cnt = 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback commit stage: load-type encodings and
// the default link offset.
package wb_pkg;

  localparam logic [2:0] LD_WORD = 3'b000;
  localparam logic [2:0] LD_LBU  = 3'b001;
  localparam logic [2:0] LD_LB   = 3'b010;
  localparam logic [2:0] LD_LHU  = 3'b011;
  localparam logic [2:0] LD_LH   = 3'b100;

  localparam int WB_PC_OFFSET = 8;

endpackage

// File: rtl/wb_load_ext.sv
// Combinational load extension: picks the addressed byte/half of a DM read
// word and sign- or zero-extends it; word and unknown codes pass raw.
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_word,
  input  logic [2:0]        i_ld_type,
  input  logic [1:0]        i_addr_lo,
  output logic [DATA_W-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte and halfword lane selection from the low address bits
  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = 8'h00;
    endcase
    if (i_addr_lo[1]) begin
      w_half = i_word[31:16];
    end else begin
      w_half = i_word[15:0];
    end
  end

  // Extension according to the load type
  always_comb begin
    o_data = i_word;
    case (i_ld_type)
      LD_LBU:  o_data = {{(DATA_W-8){1'b0}}, w_byte};
      LD_LB:   o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
      LD_LHU:  o_data = {{(DATA_W-16){1'b0}}, w_half};
      LD_LH:   o_data = {{(DATA_W-16){w_half[15]}}, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/wb_commit_stage.sv
// M/W pipeline register with write-data select, optional load extension
// (enabled by macro WB_LOAD_EXT_EN) and a retired-instruction counter.
module wb_commit_stage
  import wb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NSRC      = 3,
  parameter int DM_SRC    = 1,
  parameter int PC_OFFSET = WB_PC_OFFSET,
  parameter int AW        = 5,
  localparam int SEL_W    = $clog2(NSRC + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   m_valid,
  input  logic [SEL_W-1:0]       m_sel,
  input  logic [NSRC*DATA_W-1:0] m_src,
  input  logic [DATA_W-1:0]      m_pc,
  input  logic [AW-1:0]          m_wa,
  input  logic                   m_we,
  input  logic [2:0]             m_ld_type,
  input  logic [1:0]             m_addr_lo,
  output logic                   w_valid,
  output logic                   w_we,
  output logic [AW-1:0]          w_wa,
  output logic [DATA_W-1:0]      w_wd,
  output logic [DATA_W-1:0]      w_pc,
  output logic [31:0]            w_retire_cnt
);

  logic [DATA_W-1:0] w_dm_data;
  logic [DATA_W-1:0] w_data;
  logic              w_sel_ok;
  logic              w_we_next;

  logic              r_valid;
  logic              r_we;
  logic [AW-1:0]     r_wa;
  logic [DATA_W-1:0] r_wd;
  logic [DATA_W-1:0] r_pc;
  logic [31:0]       r_retire_cnt;

`ifdef WB_LOAD_EXT_EN
  wb_load_ext #(
    .DATA_W (DATA_W)
  ) u_load_ext (
    .i_word    (m_src[DM_SRC*DATA_W +: DATA_W]),
    .i_ld_type (m_ld_type),
    .i_addr_lo (m_addr_lo),
    .o_data    (w_dm_data)
  );
`else
  logic w_unused_ld;
  assign w_unused_ld = ^{m_ld_type, m_addr_lo};
  assign w_dm_data   = m_src[DM_SRC*DATA_W +: DATA_W];
`endif

  // Source mux: generic sources, link address, or zero for an illegal select
  always_comb begin
    w_data   = {DATA_W{1'b0}};
    w_sel_ok = (m_sel <= SEL_W'(NSRC));
    if (m_sel == SEL_W'(NSRC)) begin
      w_data = m_pc + DATA_W'(PC_OFFSET);
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (m_sel == SEL_W'(i)) begin
          if (i == DM_SRC) begin
            w_data = w_dm_data;
          end else begin
            w_data = m_src[i*DATA_W +: DATA_W];
          end
        end
      end
    end
    w_we_next = m_valid & m_we & (m_wa != {AW{1'b0}}) & w_sel_ok;
  end

  // W-stage register: reset > flush (bubble) > advance > hold
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_wa    <= {AW{1'b0}};
      r_wd    <= {DATA_W{1'b0}};
      r_pc    <= {DATA_W{1'b0}};
    end else if (flush) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_wa    <= {AW{1'b0}};
      r_wd    <= {DATA_W{1'b0}};
      r_pc    <= {DATA_W{1'b0}};
    end else if (en) begin
      r_valid <= m_valid;
      r_we    <= w_we_next;
      r_wa    <= m_wa;
      r_wd    <= w_data;
      r_pc    <= m_pc;
    end else begin
      r_valid <= r_valid;
      r_we    <= r_we;
      r_wa    <= r_wa;
      r_wd    <= r_wd;
      r_pc    <= r_pc;
    end
  end

  // The W instruction commits whenever the stage advances, even under flush
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_retire_cnt <= 32'h0000_0000;
    end else if (r_valid && en) begin
      r_retire_cnt <= r_retire_cnt + 32'h0000_0001;
    end else begin
      r_retire_cnt <= r_retire_cnt;
    end
  end

  assign w_valid      = r_valid;
  assign w_we         = r_we;
  assign w_wa         = r_wa;
  assign w_wd         = r_wd;
  assign w_pc         = r_pc;
  assign w_retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed self-checking bench for wb_commit_stage; a second instance with
// NSRC=2 exercises the out-of-range select.
module tb_wb_commit_stage;

  logic        clk = 1'b0;
  logic        reset, en, flush, m_valid, m_we;
  logic [1:0]  m_sel;
  logic [95:0] m_src;
  logic [31:0] m_pc;
  logic [4:0]  m_wa;
  logic [2:0]  m_ld_type;
  logic [1:0]  m_addr_lo;

  logic        w_valid, w_we;
  logic [4:0]  w_wa;
  logic [31:0] w_wd, w_pc, w_retire_cnt;
  logic        d2_valid, d2_we;
  logic [4:0]  d2_wa;
  logic [31:0] d2_wd, d2_pc, d2_cnt;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] cnt_before;
  logic [31:0] exp_ld [5];

  always #5 clk = ~clk;

  wb_commit_stage #(.NSRC(3)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .m_valid(m_valid),
    .m_sel(m_sel), .m_src(m_src), .m_pc(m_pc), .m_wa(m_wa), .m_we(m_we),
    .m_ld_type(m_ld_type), .m_addr_lo(m_addr_lo),
    .w_valid(w_valid), .w_we(w_we), .w_wa(w_wa), .w_wd(w_wd), .w_pc(w_pc),
    .w_retire_cnt(w_retire_cnt)
  );

  wb_commit_stage #(.NSRC(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .m_valid(m_valid),
    .m_sel(m_sel), .m_src(m_src[63:0]), .m_pc(m_pc), .m_wa(m_wa), .m_we(m_we),
    .m_ld_type(m_ld_type), .m_addr_lo(m_addr_lo),
    .w_valid(d2_valid), .w_we(d2_we), .w_wa(d2_wa), .w_wd(d2_wd), .w_pc(d2_pc),
    .w_retire_cnt(d2_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      en = 1'($urandom); flush = 1'($urandom); m_valid = 1'($urandom);
      m_we = 1'($urandom); m_sel = 2'($urandom); m_src = {$urandom, $urandom, $urandom};
      m_pc = $urandom; m_wa = 5'($urandom); m_ld_type = 3'($urandom);
      m_addr_lo = 2'($urandom);
      step();
    end
    compared++; if (w_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %0b want 0", w_valid); end
    compared++; if (w_we !== 1'b0) begin mismatched++; $display("FAIL reset_we got %0b want 0", w_we); end
    compared++; if (w_wa !== 5'd0) begin mismatched++; $display("FAIL reset_wa got %0h want 0", w_wa); end
    compared++; if (w_wd !== 32'h0) begin mismatched++; $display("FAIL reset_wd got %08h want 0", w_wd); end
    compared++; if (w_pc !== 32'h0) begin mismatched++; $display("FAIL reset_pc got %08h want 0", w_pc); end
    compared++; if (w_retire_cnt !== 32'h0) begin mismatched++; $display("FAIL reset_cnt got %08h want 0", w_retire_cnt); end
  endtask

  task automatic test_select();
    reset = 1'b1; en = 1'b1; flush = 1'b0; m_valid = 1'b1; m_we = 1'b1;
    m_wa = 5'd5; m_ld_type = 3'b000; m_addr_lo = 2'd0;
    m_src = {32'h33, 32'h22, 32'h11}; m_pc = 32'h3000;
    m_sel = 2'd0; step();
    compared++; if (w_wd !== 32'h11) begin mismatched++; $display("FAIL sel0_wd got %08h want 00000011", w_wd); end
    compared++; if ({w_valid, w_we, w_wa} !== {1'b1, 1'b1, 5'd5}) begin mismatched++; $display("FAIL sel0_ctl got %b want 1100101", {w_valid, w_we, w_wa}); end
    compared++; if (w_pc !== 32'h3000) begin mismatched++; $display("FAIL sel0_pc got %08h want 00003000", w_pc); end
    m_sel = 2'd2; step();
    compared++; if (w_wd !== 32'h33) begin mismatched++; $display("FAIL sel2_wd got %08h want 00000033", w_wd); end
    m_sel = 2'd3; step();
    compared++; if (w_wd !== 32'h3008) begin mismatched++; $display("FAIL link_wd got %08h want 00003008", w_wd); end
    compared++; if (w_we !== 1'b1) begin mismatched++; $display("FAIL link_we got %0b want 1", w_we); end
    compared++; if (w_retire_cnt !== 32'd2) begin mismatched++; $display("FAIL sel_cnt got %0d want 2", w_retire_cnt); end
  endtask

  task automatic test_load_ext();
    logic [2:0] types [5];
    logic [1:0] addrs [5];
    types = '{3'b010, 3'b001, 3'b100, 3'b011, 3'b111};
    addrs = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1};
`ifdef WB_LOAD_EXT_EN
    exp_ld = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
`else
    exp_ld = '{32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01};
`endif
    m_src = {32'h33, 32'h80FF_7F01, 32'h0000_8080}; m_sel = 2'd1;
    for (int i = 0; i < 5; i++) begin
      m_ld_type = types[i]; m_addr_lo = addrs[i];
      step();
      compared++;
      if (w_wd !== exp_ld[i]) begin
        mismatched++;
        $display("FAIL ld_ext[%0d] type=%b addr=%0d got %08h want %08h", i, types[i], addrs[i], w_wd, exp_ld[i]);
      end
    end
    m_sel = 2'd0; m_ld_type = 3'b010; m_addr_lo = 2'd0; step();
    compared++; if (w_wd !== 32'h0000_8080) begin mismatched++; $display("FAIL ld_nondm got %08h want 00008080", w_wd); end
    m_ld_type = 3'b000;
  endtask

  task automatic test_zero_badsel();
    m_sel = 2'd0; m_wa = 5'd0; m_we = 1'b1; step();
    compared++; if ({w_valid, w_we} !== 2'b10) begin mismatched++; $display("FAIL zero_reg got %b want 10", {w_valid, w_we}); end
    m_wa = 5'd9; m_sel = 2'd3; m_pc = 32'h0000_0100; step();
    compared++; if (d2_we !== 1'b0) begin mismatched++; $display("FAIL badsel_we got %0b want 0", d2_we); end
    compared++; if (d2_wd !== 32'h0) begin mismatched++; $display("FAIL badsel_wd got %08h want 0", d2_wd); end
    compared++; if ({w_we, w_wd} !== {1'b1, 32'h108}) begin mismatched++; $display("FAIL link3_n3 got %b/%08h want 1/00000108", w_we, w_wd); end
    m_sel = 2'd0; m_valid = 1'b0; step();
    compared++; if ({w_valid, w_we} !== 2'b00) begin mismatched++; $display("FAIL invalid got %b want 00", {w_valid, w_we}); end
    m_valid = 1'b1;
  endtask

  task automatic test_stall_flush();
    m_src = {32'h33, 32'h22, 32'h11}; m_sel = 2'd2; m_wa = 5'd7; m_pc = 32'h4000;
    step();
    cnt_before = w_retire_cnt;
    en = 1'b0; m_sel = 2'd0; m_wa = 5'd3; m_pc = 32'h5000;
    for (int i = 0; i < 3; i++) begin
      step();
      compared++;
      if ({w_valid, w_we, w_wa, w_wd, w_pc} !== {1'b1, 1'b1, 5'd7, 32'h33, 32'h4000} || w_retire_cnt !== cnt_before) begin
        mismatched++;
        $display("FAIL stall[%0d] got v=%0b we=%0b wa=%0d wd=%08h pc=%08h cnt=%0d want 1 1 7 00000033 00004000 %0d",
                 i, w_valid, w_we, w_wa, w_wd, w_pc, w_retire_cnt, cnt_before);
      end
    end
    en = 1'b1; flush = 1'b1; step();
    compared++;
    if ({w_valid, w_we, w_wa, w_wd, w_pc} !== {1'b0, 1'b0, 5'd0, 32'h0, 32'h0}) begin
      mismatched++;
      $display("FAIL flush got v=%0b we=%0b wa=%0d wd=%08h pc=%08h want all 0", w_valid, w_we, w_wa, w_wd, w_pc);
    end
    cnt_before = w_retire_cnt; step();
    compared++; if (w_retire_cnt !== cnt_before) begin mismatched++; $display("FAIL flush_cnt got %0d want %0d", w_retire_cnt, cnt_before); end
    flush = 1'b0; step();
    compared++; if (w_valid !== 1'b1) begin mismatched++; $display("FAIL post_flush_valid got %0b want 1", w_valid); end
  endtask

  task automatic test_wrap();
    force dut.r_retire_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_retire_cnt;
    #1;
    compared++; if (w_retire_cnt !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL wrap_preset got %08h want ffffffff", w_retire_cnt); end
    step();
    compared++; if (w_retire_cnt !== 32'h0) begin mismatched++; $display("FAIL wrap got %08h want 00000000", w_retire_cnt); end
  endtask

  task automatic test_back_to_back_reset();
    reset = 1'b0; step();
    compared++; if ({w_valid, w_we, w_retire_cnt} !== {1'b0, 1'b0, 32'h0}) begin mismatched++; $display("FAIL midreset got v=%0b we=%0b cnt=%08h want 0 0 0", w_valid, w_we, w_retire_cnt); end
    reset = 1'b1; m_sel = 2'd2; m_wa = 5'd4; step();
    compared++; if ({w_valid, w_we, w_wd, w_retire_cnt} !== {1'b1, 1'b1, 32'h33, 32'h0}) begin mismatched++; $display("FAIL after_reset got v=%0b we=%0b wd=%08h cnt=%0d want 1 1 00000033 0", w_valid, w_we, w_wd, w_retire_cnt); end
    step();
    compared++; if (w_retire_cnt !== 32'd1) begin mismatched++; $display("FAIL after_reset_cnt got %0d want 1", w_retire_cnt); end
  endtask

  initial begin
    test_reset();
    test_select();
    test_load_ext();
    test_zero_badsel();
    test_stall_flush();
    test_wrap();
    test_back_to_back_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
